// File: rtl/first_nios2_system_sysid_pkg.sv
// rtl/first_nios2_system_sysid_pkg.sv - shared types and constants for the sysid boot checker
//
// Purpose: checker FSM state encoding, sysid slave word addresses and the
// default build-time expected values used by the checker and its counter.
package first_nios2_system_sysid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_CMP   = 2'd3
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1363341622;

  localparam int unsigned LAT_CNT_W       = 3;
  localparam logic [7:0]  CHECK_COUNT_MAX = 8'd255;

endpackage

// File: rtl/first_nios2_system_sysid_lat_cnt.sv
// rtl/first_nios2_system_sysid_lat_cnt.sv - read-latency counter for the sysid checker
//
// Purpose: counts the cycles spent waiting on one sysid read so the checker
// knows which cycle carries valid readdata.
// Ports:
//   clock_i    system clock
//   reset_n_i  asynchronous active-low reset
//   clr_i      force count to 0 on next edge (wins over inc_i)
//   inc_i      increment count on next edge
//   count_o    current count
//   hit_o      count_o == READ_LATENCY
module first_nios2_system_sysid_lat_cnt
  import first_nios2_system_sysid_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [LAT_CNT_W-1:0] count_o,
  output logic                 hit_o
);

  localparam logic [LAT_CNT_W-1:0] HIT_VALUE = LAT_CNT_W'(READ_LATENCY);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign hit_o   = (cnt_q == HIT_VALUE);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// rtl/first_nios2_system_sysid_checker.sv - boot-time system-ID / timestamp checker
//
// Purpose: reads the sysid slave ID word (address 0) and build timestamp
// (address 1), registers both, compares them against build-time constants and
// reports pass/fail to the boot sequencer.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   start                 launch a check (ignored while busy)
//   sysid_address/read    slave address and one-cycle read strobe per access
//   sysid_readdata        slave read data
//   busy, done            check in progress / last check complete (sticky)
//   id_match, ts_match    per-word compare results, pass = both
//   id_value, ts_value    captured words
//   check_count           completed checks, saturating at 255
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  check_count
);

  localparam logic AUTO_PEND_RESET = (AUTO_START != 0);

  sysid_state_e state_q, state_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        pass_q, pass_d;
  logic        auto_pend_q, auto_pend_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [7:0]  check_count_q, check_count_d;

  logic                 lat_clr;
  logic                 lat_inc;
  logic                 lat_hit;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 launch;
  logic                 in_read;

  first_nios2_system_sysid_lat_cnt #(
    .READ_LATENCY(READ_LATENCY)
  ) u_lat_cnt (
    .clock_i  (clock),
    .reset_n_i(reset_n),
    .clr_i    (lat_clr),
    .inc_i    (lat_inc),
    .count_o  (lat_cnt),
    .hit_o    (lat_hit)
  );

  // An explicit start and a pending auto-start in the same cycle collapse
  // into a single launch because both only act from IDLE.
  assign launch  = (state_q == ST_IDLE) && (start || auto_pend_q);
  assign in_read = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_match_d    = id_match_q;
    ts_match_d    = ts_match_q;
    pass_d        = pass_q;
    auto_pend_d   = auto_pend_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    check_count_d = check_count_q;
    lat_clr       = 1'b0;
    lat_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d     = ST_RD_ID;
          auto_pend_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          id_match_d  = 1'b0;
          ts_match_d  = 1'b0;
          pass_d      = 1'b0;
          lat_clr     = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (lat_hit) begin
          id_value_d = sysid_readdata;
          state_d    = ST_RD_TS;
          lat_clr    = 1'b1;
        end else begin
          lat_inc = 1'b1;
        end
      end
      ST_RD_TS: begin
        if (lat_hit) begin
          ts_value_d = sysid_readdata;
          state_d    = ST_CMP;
          lat_clr    = 1'b1;
        end else begin
          lat_inc = 1'b1;
        end
      end
      ST_CMP: begin
        id_match_d = (id_value_q == EXPECTED_ID);
        ts_match_d = (ts_value_q == EXPECTED_TS);
        pass_d     = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
        done_d     = 1'b1;
        busy_d     = 1'b0;
        if (check_count_q != CHECK_COUNT_MAX) begin
          check_count_d = check_count_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      pass_q        <= 1'b0;
      auto_pend_q   <= AUTO_PEND_RESET;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      check_count_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      pass_q        <= pass_d;
      auto_pend_q   <= auto_pend_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      check_count_q <= check_count_d;
    end
  end

  // The latency counter is cleared on entry to each read phase, so a zero
  // count marks the first cycle of the phase: the only cycle that strobes.
  assign sysid_read    = in_read && (lat_cnt == '0);
  assign sysid_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign pass        = pass_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign check_count = check_count_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb/tb_first_nios2_system_sysid_checker.sv - self-checking bench for the sysid boot checker
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1363341622;
  localparam logic [31:0] BAD_TS  = 32'h51430B37;
  localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        idm;
    logic        tsm;
    logic        pass;
    logic [7:0]  cnt;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: latency 0, auto-start enabled.
  logic        a_rst_n = 1'b0;
  logic        a_start = 1'b0;
  logic        a_address, a_read, a_busy, a_done, a_id_match, a_ts_match, a_pass;
  logic [31:0] a_readdata, a_id_value, a_ts_value;
  logic [7:0]  a_check_count;
  logic [31:0] a_id_data = EXP_ID;
  logic [31:0] a_ts_data = EXP_TS;

  // Instance B: latency 3, auto-start disabled.
  logic        b_rst_n = 1'b0;
  logic        b_start = 1'b0;
  logic        b_address, b_read, b_busy, b_done, b_id_match, b_ts_match, b_pass;
  logic [31:0] b_readdata, b_id_value, b_ts_value;
  logic [7:0]  b_check_count;
  logic [31:0] b_id_data = EXP_ID;
  logic [31:0] b_ts_data = EXP_TS;

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0), .AUTO_START(1)
  ) u_a (
    .clock(clock), .reset_n(a_rst_n), .start(a_start),
    .sysid_address(a_address), .sysid_read(a_read), .sysid_readdata(a_readdata),
    .busy(a_busy), .done(a_done), .id_match(a_id_match), .ts_match(a_ts_match),
    .pass(a_pass), .id_value(a_id_value), .ts_value(a_ts_value),
    .check_count(a_check_count)
  );

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(3), .AUTO_START(0)
  ) u_b (
    .clock(clock), .reset_n(b_rst_n), .start(b_start),
    .sysid_address(b_address), .sysid_read(b_read), .sysid_readdata(b_readdata),
    .busy(b_busy), .done(b_done), .id_match(b_id_match), .ts_match(b_ts_match),
    .pass(b_pass), .id_value(b_id_value), .ts_value(b_ts_value),
    .check_count(b_check_count)
  );

  // Zero-latency slave: data only while the strobe is up, garbage otherwise.
  assign a_readdata = a_read ? (a_address ? a_ts_data : a_id_data) : GARBAGE;

  // Three-cycle slave: counts negedges from the strobe; valid only for the
  // rising edge that ends the third cycle after the strobe cycle.
  logic [2:0] b_cnt = 3'd0;
  logic       b_pend_addr = 1'b0;
  always @(negedge clock) begin
    if (b_read) begin
      b_cnt       <= 3'd1;
      b_pend_addr <= b_address;
    end else if (b_cnt == 3'd4) begin
      b_cnt <= 3'd0;
    end else if (b_cnt != 3'd0) begin
      b_cnt <= b_cnt + 3'd1;
    end
  end
  assign b_readdata = (b_cnt == 3'd4) ? (b_pend_addr ? b_ts_data : b_id_data) : GARBAGE;

  int   checks = 0;
  int   errors = 0;
  int   a_model_cnt = 0;
  int   b_model_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic exp_t model_a();
    exp_t e;
    e.id   = a_id_data;
    e.ts   = a_ts_data;
    e.idm  = (a_id_data == EXP_ID);
    e.tsm  = (a_ts_data == EXP_TS);
    e.pass = e.idm && e.tsm;
    if (a_model_cnt < 255) a_model_cnt++;
    e.cnt  = 8'(a_model_cnt);
    return e;
  endfunction

  function automatic exp_t model_b();
    exp_t e;
    e.id   = b_id_data;
    e.ts   = b_ts_data;
    e.idm  = (b_id_data == EXP_ID);
    e.tsm  = (b_ts_data == EXP_TS);
    e.pass = e.idm && e.tsm;
    if (b_model_cnt < 255) b_model_cnt++;
    e.cnt  = 8'(b_model_cnt);
    return e;
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({a_busy, a_done, a_id_match, a_ts_match, a_pass, a_read, a_address} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a_flags got %b want 0000000",
               {a_busy, a_done, a_id_match, a_ts_match, a_pass, a_read, a_address});
    end
    checks++;
    if ({a_id_value, a_ts_value, a_check_count} !== 72'b0) begin
      errors++;
      $display("FAIL reset_a_values got %h/%h/%0d want 0/0/0", a_id_value, a_ts_value, a_check_count);
    end
    checks++;
    if ({b_busy, b_done, b_id_match, b_ts_match, b_pass, b_read, b_address} !== 7'b0) begin
      errors++;
      $display("FAIL reset_b_flags got %b want 0000000",
               {b_busy, b_done, b_id_match, b_ts_match, b_pass, b_read, b_address});
    end
    checks++;
    if ({b_id_value, b_ts_value, b_check_count} !== 72'b0) begin
      errors++;
      $display("FAIL reset_b_values got %h/%h/%0d want 0/0/0", b_id_value, b_ts_value, b_check_count);
    end
  endtask

  task automatic test_auto_start();
    int   edges, reads;
    exp_t e;
    qa.push_back(model_a());
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    edges = 0;
    reads = 0;
    while (!a_done && edges < 20) begin
      @(negedge clock);
      edges++;
      if (a_read) reads++;
    end
    // launch edge is the first edge after release, done three edges later
    checks++;
    if (edges !== 4) begin
      errors++;
      $display("FAIL auto_start_latency got %0d edges want 4", edges);
    end
    checks++;
    if (reads !== 2) begin
      errors++;
      $display("FAIL auto_start_reads got %0d want 2", reads);
    end
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL auto_start_scoreboard got empty want entry");
    end else begin
      e = qa.pop_front();
      checks++;
      if ({a_id_value, a_ts_value} !== {e.id, e.ts}) begin
        errors++;
        $display("FAIL auto_start_values got %h/%h want %h/%h", a_id_value, a_ts_value, e.id, e.ts);
      end
      checks++;
      if ({a_id_match, a_ts_match, a_pass, a_busy} !== {e.idm, e.tsm, e.pass, 1'b0}) begin
        errors++;
        $display("FAIL auto_start_flags got %b want %b",
                 {a_id_match, a_ts_match, a_pass, a_busy}, {e.idm, e.tsm, e.pass, 1'b0});
      end
      checks++;
      if (a_check_count !== e.cnt) begin
        errors++;
        $display("FAIL auto_start_count got %0d want %0d", a_check_count, e.cnt);
      end
    end
  endtask

  task automatic run_b_check(input string name);
    int   edges, reads;
    exp_t e;
    qb.push_back(model_b());
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    edges = 0;
    reads = b_read ? 1 : 0;
    while (!b_done && edges < 40) begin
      @(negedge clock);
      edges++;
      if (b_read) reads++;
    end
    checks++;
    if (edges !== 9) begin
      errors++;
      $display("FAIL %s_latency got %0d edges want 9", name, edges);
    end
    checks++;
    if (reads !== 2) begin
      errors++;
      $display("FAIL %s_reads got %0d want 2", name, reads);
    end
    checks++;
    if (qb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty want entry", name);
    end else begin
      e = qb.pop_front();
      checks++;
      if ({b_id_value, b_ts_value} !== {e.id, e.ts}) begin
        errors++;
        $display("FAIL %s_values got %h/%h want %h/%h", name, b_id_value, b_ts_value, e.id, e.ts);
      end
      checks++;
      if ({b_id_match, b_ts_match, b_pass, b_busy} !== {e.idm, e.tsm, e.pass, 1'b0}) begin
        errors++;
        $display("FAIL %s_flags got %b want %b", name,
                 {b_id_match, b_ts_match, b_pass, b_busy}, {e.idm, e.tsm, e.pass, 1'b0});
      end
      checks++;
      if (b_check_count !== e.cnt) begin
        errors++;
        $display("FAIL %s_count got %0d want %0d", name, b_check_count, e.cnt);
      end
    end
  endtask

  task automatic test_no_auto_start();
    int reads;
    reads = 0;
    repeat (20) begin
      @(negedge clock);
      if (b_read || b_busy) reads++;
    end
    checks++;
    if (reads !== 0) begin
      errors++;
      $display("FAIL no_auto_idle got %0d active cycles want 0", reads);
    end
    run_b_check("no_auto_start");
    reads = 0;
    repeat (10) begin
      @(negedge clock);
      if (b_read || b_busy) reads++;
    end
    checks++;
    if (reads !== 0) begin
      errors++;
      $display("FAIL no_auto_single got %0d active cycles after one start want 0", reads);
    end
  endtask

  task automatic test_lat3_mismatch();
    b_ts_data = BAD_TS;
    run_b_check("lat3_mismatch");
  endtask

  task automatic test_start_while_busy();
    int   extra;
    exp_t e;
    qa.push_back(model_a());
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    @(negedge clock);
    checks++;
    if ({a_address, a_busy} !== 2'b11) begin
      errors++;
      $display("FAIL busy_start_phase got addr/busy %b want 11", {a_address, a_busy});
    end
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    @(negedge clock);
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_done got %b want 1", a_done);
    end
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL busy_start_scoreboard got empty want entry");
    end else begin
      e = qa.pop_front();
      checks++;
      if ({a_check_count, a_pass} !== {e.cnt, e.pass}) begin
        errors++;
        $display("FAIL busy_start_result got cnt %0d pass %b want cnt %0d pass %b",
                 a_check_count, a_pass, e.cnt, e.pass);
      end
    end
    extra = 0;
    repeat (8) begin
      @(negedge clock);
      if (a_busy || a_read || !a_done) extra++;
    end
    checks++;
    if (extra !== 0 || a_check_count !== 8'(a_model_cnt)) begin
      errors++;
      $display("FAIL busy_start_not_queued got %0d active cycles cnt %0d want 0 cnt %0d",
               extra, a_check_count, a_model_cnt);
    end
  endtask

  task automatic test_reset_mid_check();
    int   edges;
    exp_t e;
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    #2;
    a_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_pass, a_read, a_id_match, a_ts_match} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got %b want 000000",
               {a_busy, a_done, a_pass, a_read, a_id_match, a_ts_match});
    end
    checks++;
    if ({a_id_value, a_ts_value, a_check_count} !== 72'b0) begin
      errors++;
      $display("FAIL mid_reset_values got %h/%h/%0d want 0/0/0", a_id_value, a_ts_value, a_check_count);
    end
    a_model_cnt = 0;
    @(negedge clock);
    qa.push_back(model_a());
    a_rst_n = 1'b1;
    edges = 0;
    while (!a_done && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    checks++;
    if (edges !== 4) begin
      errors++;
      $display("FAIL mid_reset_relaunch got %0d edges want 4", edges);
    end
    checks++;
    if (qa.size() == 0) begin
      errors++;
      $display("FAIL mid_reset_scoreboard got empty want entry");
    end else begin
      e = qa.pop_front();
      checks++;
      if ({a_ts_value, a_check_count, a_pass} !== {e.ts, e.cnt, e.pass}) begin
        errors++;
        $display("FAIL mid_reset_result got %h/%0d/%b want %h/%0d/%b",
                 a_ts_value, a_check_count, a_pass, e.ts, e.cnt, e.pass);
      end
    end
  endtask

  task automatic test_saturation();
    int   low, reads, cyc;
    exp_t e;
    a_start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      qa.push_back(model_a());
      low = 0;
      reads = 0;
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
        if (a_read) reads++;
        if (!a_done) low++;
      end while (!(a_done && low > 0) && cyc < 20);
      checks++;
      if (low !== 3) begin
        errors++;
        $display("FAIL sat_done_low check %0d got %0d cycles want 3", i, low);
      end
      checks++;
      if (reads !== 2) begin
        errors++;
        $display("FAIL sat_reads check %0d got %0d want 2", i, reads);
      end
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sat_scoreboard check %0d got empty want entry", i);
      end else begin
        e = qa.pop_front();
        checks++;
        if ({a_check_count, a_pass} !== {e.cnt, e.pass}) begin
          errors++;
          $display("FAIL sat_count check %0d got %0d/%b want %0d/%b", i, a_check_count, a_pass, e.cnt, e.pass);
        end
      end
    end
    a_start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({a_check_count, a_busy, a_done} !== {8'd255, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_final got cnt %0d busy %b done %b want 255 0 1", a_check_count, a_busy, a_done);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_no_auto_start();
    test_lat3_mismatch();
    test_start_while_busy();
    test_reset_mid_check();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
